// File: rtl/vga_native_regfile_if.sv
// vga_native_regfile_if: native write/read bus between the AXI-Lite slave FSM and the register bank
// master: FSM side, drives strobes/addresses/write data and receives read data
// slave : register bank side
interface vga_native_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_en_i;
  logic [ADDR_WIDTH-1:0] addr_write_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  read_en_sync_i;
  logic [ADDR_WIDTH-1:0] addr_read_i;
  logic [DATA_WIDTH-1:0] data_o;
  modport master (
    output write_en_i, addr_write_i, data_i, read_en_sync_i, addr_read_i,
    input  data_o
  );
  modport slave (
    input  write_en_i, addr_write_i, data_i, read_en_sync_i, addr_read_i,
    output data_o
  );
endinterface

// File: rtl/vga_native_regfile.sv
// vga_native_regfile: VGA config register bank with frame-aligned shadow commit, sticky frame IRQ and frame counter
// clk_i, arst_n_i        : clock, async active-low reset
// bus (slave)            : write strobe/addr/data, read strobe/addr, read data (1 clk latency)
// frame_start_i          : 1-cycle frame start pulse from VGA timing
// vga_en_o/pattern_en_o  : active CTRL[0]/CTRL[1]
// bg_color_o             : active BG_COLOR[11:0]
// irq_o                  : registered IRQ_STATUS[0] & IRQ_EN[0]
module vga_native_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  vga_native_regfile_if.slave   bus,
  input  logic                  frame_start_i,
  output logic                  vga_en_o,
  output logic                  pattern_en_o,
  output logic [11:0]           bg_color_o,
  output logic                  irq_o
);
  logic [1:0]            r_ctrl_sh, r_ctrl_act;
  logic [11:0]           r_bg_sh, r_bg_act;
  logic                  r_irq_stat, r_irq_en, r_irq;
  logic [DATA_WIDTH-1:0] r_frame_cnt, r_scratch, r_data;
  logic                  r_cfg_wr;
  logic                  w_wr_ctrl, w_wr_bg, w_wr_stat, w_wr_en, w_wr_scr, w_commit;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_wr_ctrl = bus.write_en_i && bus.addr_write_i == ADDR_WIDTH'(0);
  assign w_wr_bg   = bus.write_en_i && bus.addr_write_i == ADDR_WIDTH'(1);
  assign w_wr_stat = bus.write_en_i && bus.addr_write_i == ADDR_WIDTH'(2);
  assign w_wr_en   = bus.write_en_i && bus.addr_write_i == ADDR_WIDTH'(3);
  assign w_wr_scr  = bus.write_en_i && bus.addr_write_i == ADDR_WIDTH'(5);
  // While the display is off, a config write is pushed to the outputs the
  // following edge so the very first enable does not wait for a frame.
  assign w_commit  = frame_start_i || (r_cfg_wr && !r_ctrl_act[0]);

  // Read mux samples pre-edge state, so same-edge writes/increments are not seen.
  always_comb begin
    w_rd = (bus.addr_read_i == ADDR_WIDTH'(0)) ? DATA_WIDTH'(r_ctrl_sh) :
           (bus.addr_read_i == ADDR_WIDTH'(1)) ? DATA_WIDTH'(r_bg_sh) :
           (bus.addr_read_i == ADDR_WIDTH'(2)) ? DATA_WIDTH'(r_irq_stat) :
           (bus.addr_read_i == ADDR_WIDTH'(3)) ? DATA_WIDTH'(r_irq_en) :
           (bus.addr_read_i == ADDR_WIDTH'(4)) ? r_frame_cnt :
           (bus.addr_read_i == ADDR_WIDTH'(5)) ? r_scratch : '0;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ctrl_sh   <= '0;
      r_ctrl_act  <= '0;
      r_bg_sh     <= '0;
      r_bg_act    <= '0;
      r_irq_stat  <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_frame_cnt <= '0;
      r_scratch   <= '0;
      r_data      <= '0;
      r_cfg_wr    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl_sh <= bus.data_i[1:0];
      if (w_wr_bg) r_bg_sh <= bus.data_i[11:0];
      if (w_wr_en) r_irq_en <= bus.data_i[0];
      if (w_wr_scr) r_scratch <= bus.data_i;
      r_cfg_wr <= w_wr_ctrl || w_wr_bg;
      if (w_commit) begin
        r_ctrl_act <= r_ctrl_sh;
        r_bg_act   <= r_bg_sh;
      end
      // Frame-done set has priority over a W1C on the same edge.
      r_irq_stat <= frame_start_i || (r_irq_stat && !(w_wr_stat && bus.data_i[0]));
      r_irq      <= r_irq_stat && r_irq_en;
      if (frame_start_i) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (bus.read_en_sync_i) r_data <= w_rd;
    end
  end

  assign bus.data_o   = r_data;
  assign vga_en_o     = r_ctrl_act[0];
  assign pattern_en_o = r_ctrl_act[1];
  assign bg_color_o   = r_bg_act;
  assign irq_o        = r_irq;
endmodule

// File: tb/tb_vga_native_regfile.sv
// tb_vga_native_regfile: directed self-checking bench for vga_native_regfile
module tb_vga_native_regfile;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        vga_en, pattern_en, irq;
  logic [11:0] bg_color;
  int          total = 0;
  int          bad = 0;
  int unsigned n_frames = 0;

  vga_native_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  vga_native_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .bus(bus), .frame_start_i(frame_start),
    .vga_en_o(vga_en), .pattern_en_o(pattern_en), .bg_color_o(bg_color), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic re, input logic [3:0] ra, input logic fs);
    @(negedge clk);
    bus.write_en_i = we; bus.addr_write_i = wa; bus.data_i = wd;
    bus.read_en_sync_i = re; bus.addr_read_i = ra; frame_start = fs;
    @(posedge clk);
    #1;
    bus.write_en_i = 1'b0; bus.read_en_sync_i = 1'b0; frame_start = 1'b0;
    if (fs) n_frames++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b0, 4'd0, 32'd0, 1'b1, a, 1'b0);
  endtask

  task automatic pulse();
    cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a <= 6; a++) begin
      rd(4'(a));
      chk($sformatf("reset_rd%0d", a), bus.data_o, 32'd0);
    end
    chk("reset_vga_en", 32'(vga_en), 32'd0);
    chk("reset_bg", 32'(bg_color), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
  endtask

  task automatic test_commit();
    wr(4'd1, 32'h0000_0ABC);
    wr(4'd0, 32'h1);
    chk("pre_bypass_vga_en", 32'(vga_en), 32'd0);
    @(posedge clk); #1;
    chk("bypass_vga_en", 32'(vga_en), 32'd1);
    chk("bypass_bg", 32'(bg_color), 32'hABC);
    wr(4'd1, 32'hFFFF_F123);
    @(posedge clk); @(posedge clk); #1;
    chk("bg_held", 32'(bg_color), 32'hABC);
    rd(4'd1);
    chk("bg_shadow_rd", bus.data_o, 32'h123);
    pulse();
    chk("bg_commit", 32'(bg_color), 32'h123);
    chk("pattern_off", 32'(pattern_en), 32'd0);
  endtask

  task automatic test_irq();
    wr(4'd2, 32'h1);
    wr(4'd3, 32'h1);
    @(posedge clk); #1;
    chk("irq_idle", 32'(irq), 32'd0);
    pulse();
    chk("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    rd(4'd2);
    chk("irq_stat_rd", bus.data_o, 32'd1);
    wr(4'd2, 32'h1);
    @(posedge clk); #1;
    chk("irq_w1c", 32'(irq), 32'd0);
    cycle(1'b1, 4'd2, 32'h1, 1'b0, 4'd0, 1'b1);
    rd(4'd2);
    chk("irq_set_wins", bus.data_o, 32'd1);
    chk("irq_set_wins_out", 32'(irq), 32'd1);
  endtask

  task automatic test_frame_cnt();
    pulse(); pulse(); pulse();
    rd(4'd4);
    chk("frame_cnt", bus.data_o, n_frames);
    @(negedge clk);
    force dut.r_frame_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_frame_cnt;
    pulse();
    rd(4'd4);
    chk("frame_cnt_wrap", bus.data_o, 32'd0);
    wr(4'd4, 32'h55);
    rd(4'd4);
    chk("frame_cnt_ro", bus.data_o, 32'd0);
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 1'b1);
    chk("frame_cnt_pre_inc", bus.data_o, 32'd0);
    rd(4'd4);
    chk("frame_cnt_post_inc", bus.data_o, 32'd1);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd5, 1'b0);
    chk("scratch_same_edge", bus.data_o, 32'd0);
    rd(4'd5);
    chk("scratch_rd", bus.data_o, 32'hDEAD_BEEF);
    wr(4'd7, 32'h1234_5678);
    rd(4'd7);
    chk("unmapped_rd", bus.data_o, 32'd0);
    rd(4'd5);
    chk("unmapped_scratch", bus.data_o, 32'hDEAD_BEEF);
    rd(4'd1);
    chk("unmapped_bg", bus.data_o, 32'h123);
    rd(4'd0);
    chk("unmapped_ctrl", bus.data_o, 32'h1);
  endtask

  task automatic test_async_reset();
    wr(4'd0, 32'h2);
    @(negedge clk); #2;
    arst_n = 1'b0;
    #1;
    chk("arst_vga_en", 32'(vga_en), 32'd0);
    chk("arst_bg", 32'(bg_color), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_data", bus.data_o, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    pulse();
    @(posedge clk); #1;
    chk("post_rst_vga_en", 32'(vga_en), 32'd0);
    chk("post_rst_pattern", 32'(pattern_en), 32'd0);
    chk("post_rst_bg", 32'(bg_color), 32'd0);
    rd(4'd0);
    chk("post_rst_ctrl", bus.data_o, 32'd0);
    rd(4'd5);
    chk("post_rst_scratch", bus.data_o, 32'd0);
  endtask

  initial begin
    bus.write_en_i = 1'b0; bus.addr_write_i = '0; bus.data_i = '0;
    bus.read_en_sync_i = 1'b0; bus.addr_read_i = '0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    test_reset();
    test_commit();
    test_irq();
    test_frame_cnt();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
